// File: rtl/mem_perf_pkg.sv
// Shared types and helpers for the memory traffic / latency monitor.
// Build option consumed elsewhere: MEM_LAT_MONITOR_SAT_EN.
package mem_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } mem_perf_state_e;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int MEM_PERF_CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_perf_popcount.sv
// Combinational population count of an N-bit vector.
module mem_perf_popcount
  import mem_perf_pkg::*;
#(
  parameter int N = 4,
  localparam int W = MEM_PERF_CNT_W(N)
) (
  input  logic [N-1:0] i_bits,
  output logic [W-1:0] o_count
);

  // Sum the set bits lane by lane.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/mem_lat_monitor.sv
// Multi-channel memory traffic and latency monitor.
// Counts read/write request fires inside a run/hold/clear window, tracks
// outstanding reads, integrates them into a latency sum and keeps the peak.
// Build option MEM_LAT_MONITOR_SAT_EN: window counters saturate instead of
// wrapping. The outstanding-read count saturates in every build.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | window closed, counters hold their last values
// ST_RUN  | window open, counters accumulate every cycle
// ST_HOLD | window paused, counters frozen until resumed
module mem_lat_monitor
  import mem_perf_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CTR_W        = 44,
  parameter int PEND_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ctl_start,
  input  logic                    ctl_stop,
  input  logic                    ctl_clear,
  input  logic [NUM_CHANNELS-1:0] req_valid,
  input  logic [NUM_CHANNELS-1:0] req_ready,
  input  logic [NUM_CHANNELS-1:0] req_rw,
  input  logic [NUM_CHANNELS-1:0] rsp_valid,
  input  logic [NUM_CHANNELS-1:0] rsp_ready,
  output logic [CTR_W-1:0]        reads,
  output logic [CTR_W-1:0]        writes,
  output logic [CTR_W-1:0]        latency_sum,
  output logic [PEND_W-1:0]       pending,
  output logic [PEND_W-1:0]       max_pending,
  output logic [1:0]              state,
  output logic                    err_underflow
);

  localparam int CNT_W  = MEM_PERF_CNT_W(NUM_CHANNELS);
  // Two guard bits: one for overflow above all-ones, one as the sign bit.
  // Sufficient as long as the per-cycle count fits in PEND_W bits.
  localparam int CALC_W = PEND_W + 2;

  logic [NUM_CHANNELS-1:0] w_rd_fire;
  logic [NUM_CHANNELS-1:0] w_wr_fire;
  logic [NUM_CHANNELS-1:0] w_rsp_fire;
  logic [CNT_W-1:0]        w_rd_pop;
  logic [CNT_W-1:0]        w_wr_pop;
  logic [CNT_W-1:0]        w_rsp_cnt;

  logic [CNT_W-1:0]        r_rd_cnt;
  logic [CNT_W-1:0]        r_wr_cnt;

  logic [CALC_W-1:0]       w_pend_sum;
  logic                    w_pend_neg;
  logic                    w_pend_ovf;
  logic [PEND_W-1:0]       w_pend_next;
  logic [PEND_W-1:0]       w_max_next;

  logic [CTR_W-1:0]        w_reads_next;
  logic [CTR_W-1:0]        w_writes_next;
  logic [CTR_W-1:0]        w_lat_next;

  mem_perf_state_e         r_state;
  logic [CTR_W-1:0]        r_reads;
  logic [CTR_W-1:0]        r_writes;
  logic [CTR_W-1:0]        r_latency_sum;
  logic [PEND_W-1:0]       r_pending;
  logic [PEND_W-1:0]       r_max_pending;
  logic                    r_err_underflow;

  assign w_rd_fire  = req_valid & req_ready & ~req_rw;
  assign w_wr_fire  = req_valid & req_ready &  req_rw;
  assign w_rsp_fire = rsp_valid & rsp_ready;

  mem_perf_popcount #(.N(NUM_CHANNELS)) u_pop_rd (
    .i_bits  (w_rd_fire),
    .o_count (w_rd_pop)
  );

  mem_perf_popcount #(.N(NUM_CHANNELS)) u_pop_wr (
    .i_bits  (w_wr_fire),
    .o_count (w_wr_pop)
  );

  mem_perf_popcount #(.N(NUM_CHANNELS)) u_pop_rsp (
    .i_bits  (w_rsp_fire),
    .o_count (w_rsp_cnt)
  );

  // Register the request counts; responses are used directly, so a read
  // needs two edges to show up while a response retires after one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_rd_cnt <= w_rd_pop;
      r_wr_cnt <= w_wr_pop;
    end
  end

  // Outstanding-read update with clamping at both ends; MSB is the sign.
  always_comb begin
    w_pend_sum  = {2'b00, r_pending} + CALC_W'(r_rd_cnt) - CALC_W'(w_rsp_cnt);
    w_pend_neg  = w_pend_sum[CALC_W-1];
    w_pend_ovf  = ~w_pend_sum[CALC_W-1] & w_pend_sum[PEND_W];
    w_pend_next = w_pend_sum[PEND_W-1:0];
    if (w_pend_neg) begin
      w_pend_next = '0;
    end else if (w_pend_ovf) begin
      w_pend_next = '1;
    end
    w_max_next = (w_pend_next > r_max_pending) ? w_pend_next : r_max_pending;
  end

`ifdef MEM_LAT_MONITOR_SAT_EN
  localparam int SUM_W = ((CTR_W > PEND_W) ? CTR_W : PEND_W) + 1;

  logic [SUM_W-1:0] w_reads_sum;
  logic [SUM_W-1:0] w_writes_sum;
  logic [SUM_W-1:0] w_lat_sum;

  // Window counter increments, sticking at all-ones once they overflow.
  always_comb begin
    w_reads_sum   = SUM_W'(r_reads)       + SUM_W'(r_rd_cnt);
    w_writes_sum  = SUM_W'(r_writes)      + SUM_W'(r_wr_cnt);
    w_lat_sum     = SUM_W'(r_latency_sum) + SUM_W'(r_pending);
    w_reads_next  = (|w_reads_sum[SUM_W-1:CTR_W])  ? '1 : w_reads_sum[CTR_W-1:0];
    w_writes_next = (|w_writes_sum[SUM_W-1:CTR_W]) ? '1 : w_writes_sum[CTR_W-1:0];
    w_lat_next    = (|w_lat_sum[SUM_W-1:CTR_W])    ? '1 : w_lat_sum[CTR_W-1:0];
  end
`else
  // Window counter increments, wrapping modulo 2^CTR_W.
  always_comb begin
    w_reads_next  = r_reads       + CTR_W'(r_rd_cnt);
    w_writes_next = r_writes      + CTR_W'(r_wr_cnt);
    w_lat_next    = r_latency_sum + CTR_W'(r_pending);
  end
`endif

  // Window FSM and counters; pending tracks in every state so nothing in
  // flight is lost across hold or clear. Clear beats stop beats start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_reads         <= '0;
      r_writes        <= '0;
      r_latency_sum   <= '0;
      r_pending       <= '0;
      r_max_pending   <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      if (ctl_clear) begin
        r_reads         <= '0;
        r_writes        <= '0;
        r_latency_sum   <= '0;
        r_max_pending   <= '0;
        r_err_underflow <= 1'b0;
        r_state         <= ctl_start ? ST_RUN : ST_IDLE;
      end else begin
        if (w_pend_neg) begin
          r_err_underflow <= 1'b1;
        end
        if (r_state == ST_RUN) begin
          r_reads       <= w_reads_next;
          r_writes      <= w_writes_next;
          r_latency_sum <= w_lat_next;
          r_max_pending <= w_max_next;
        end
        case (r_state)
          ST_IDLE: if (!ctl_stop && ctl_start) r_state <= ST_RUN;
          ST_RUN:  if (ctl_stop)               r_state <= ST_HOLD;
          ST_HOLD: if (!ctl_stop && ctl_start) r_state <= ST_RUN;
          default:                             r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign reads         = r_reads;
  assign writes        = r_writes;
  assign latency_sum   = r_latency_sum;
  assign pending       = r_pending;
  assign max_pending   = r_max_pending;
  assign state         = r_state;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_mem_lat_monitor.sv
// Bench for mem_lat_monitor: a default-width instance and a narrow instance
// (CTR_W=4, PEND_W=3) share the same stimulus so wrap/saturation and the
// pending clamp are exercised alongside the normal counting behaviour.
module tb_mem_lat_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       ctl_start, ctl_stop, ctl_clear;
  logic [3:0] req_valid, req_ready, req_rw, rsp_valid, rsp_ready;

  logic [43:0] reads, writes, latency_sum;
  logic [15:0] pending, max_pending;
  logic [1:0]  state;
  logic        err_underflow;

  logic [3:0] s_reads, s_writes, s_latency_sum;
  logic [2:0] s_pending, s_max_pending;
  logic [1:0] s_state;
  logic       s_err_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lat_monitor dut (
    .clk(clk), .reset(reset),
    .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_clear(ctl_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .reads(reads), .writes(writes), .latency_sum(latency_sum),
    .pending(pending), .max_pending(max_pending),
    .state(state), .err_underflow(err_underflow)
  );

  mem_lat_monitor #(.NUM_CHANNELS(4), .CTR_W(4), .PEND_W(3)) dut_s (
    .clk(clk), .reset(reset),
    .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_clear(ctl_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .reads(s_reads), .writes(s_writes), .latency_sum(s_latency_sum),
    .pending(s_pending), .max_pending(s_max_pending),
    .state(s_state), .err_underflow(s_err_underflow)
  );

  // Model: totals since last clear are kept unbounded and folded into the
  // counter width only when compared. Index 0 = default instance, 1 = narrow.
  longint rd_tot[2], wr_tot[2], lat_tot[2];
  int     pend[2], maxp[2];
  bit     err[2];
  int     rd_d, wr_d;   // request counts seen one edge ago
  int     mstate;       // 0 idle, 1 run, 2 hold
  bit     mdl_ok = 0;

  function automatic int pmax(input int k);
    return (k == 1) ? 7 : 65535;
  endfunction

  function automatic int cwid(input int k);
    return (k == 1) ? 4 : 44;
  endfunction

  function automatic longint exp_ctr(input longint tot, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
`ifdef MEM_LAT_MONITOR_SAT_EN
    return (tot > lim) ? lim : tot;
`else
    return tot & lim;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int rdn, wrn, rspn, pn;
    bit uf;
    rdn  = $countones(req_valid & req_ready & ~req_rw);
    wrn  = $countones(req_valid & req_ready & req_rw);
    rspn = $countones(rsp_valid & rsp_ready);
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        rd_tot[k] = 0; wr_tot[k] = 0; lat_tot[k] = 0;
        pend[k] = 0; maxp[k] = 0; err[k] = 0;
      end
      rd_d = 0; wr_d = 0; mstate = 0;
      mdl_ok = 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        uf = 0;
        pn = pend[k] + rd_d - rspn;
        if (pn < 0) begin pn = 0; uf = 1; end
        if (pn > pmax(k)) pn = pmax(k);
        if (ctl_clear) begin
          rd_tot[k] = 0; wr_tot[k] = 0; lat_tot[k] = 0; maxp[k] = 0; err[k] = 0;
        end else begin
          if (uf) err[k] = 1;
          if (mstate == 1) begin
            rd_tot[k]  += rd_d;
            wr_tot[k]  += wr_d;
            lat_tot[k] += pend[k];
            if (pn > maxp[k]) maxp[k] = pn;
          end
        end
        pend[k] = pn;
      end
      if (ctl_clear)                      mstate = ctl_start ? 1 : 0;
      else if (ctl_stop)                  mstate = (mstate == 1) ? 2 : mstate;
      else if (ctl_start)                 mstate = 1;
      rd_d = rdn;
      wr_d = wrn;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (mdl_ok && !reset) begin
      chk("m_reads",   64'(reads),         64'(exp_ctr(rd_tot[0], cwid(0))));
      chk("m_writes",  64'(writes),        64'(exp_ctr(wr_tot[0], cwid(0))));
      chk("m_latency", 64'(latency_sum),   64'(exp_ctr(lat_tot[0], cwid(0))));
      chk("m_pending", 64'(pending),       64'(pend[0]));
      chk("m_maxpend", 64'(max_pending),   64'(maxp[0]));
      chk("m_state",   64'(state),         64'(mstate));
      chk("m_err",     64'(err_underflow), 64'(err[0]));
      chk("s_reads",   64'(s_reads),         64'(exp_ctr(rd_tot[1], cwid(1))));
      chk("s_writes",  64'(s_writes),        64'(exp_ctr(wr_tot[1], cwid(1))));
      chk("s_latency", 64'(s_latency_sum),   64'(exp_ctr(lat_tot[1], cwid(1))));
      chk("s_pending", 64'(s_pending),       64'(pend[1]));
      chk("s_maxpend", 64'(s_max_pending),   64'(maxp[1]));
      chk("s_state",   64'(s_state),         64'(mstate));
      chk("s_err",     64'(s_err_underflow), 64'(err[1]));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ctl_start = 0; ctl_stop = 0; ctl_clear = 0;
    req_valid = 0; req_ready = 0; req_rw = 0;
    rsp_valid = 0; rsp_ready = 0;
  endtask

  task automatic rd_lanes(input logic [3:0] m);
    req_valid = m; req_ready = m; req_rw = 4'b0000;
  endtask

  task automatic rsp_lanes(input logic [3:0] m);
    rsp_valid = m; rsp_ready = m;
  endtask

  initial begin
    idle();
    reset = 1;
    step(2);
    reset = 0;

    // reset state
    chk("rst_reads",   64'(reads), 0);
    chk("rst_writes",  64'(writes), 0);
    chk("rst_latency", 64'(latency_sum), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_maxpend", 64'(max_pending), 0);
    chk("rst_state",   64'(state), 0);
    chk("rst_err",     64'(err_underflow), 0);

    // single read, response nine cycles after it becomes visible
    ctl_start = 1; step(); ctl_start = 0;
    chk("t1_state_run", 64'(state), 1);
    step(2);
    rd_lanes(4'b0001); step(); idle(); step();
    chk("t1_reads", 64'(reads), 1);
    chk("t1_pend1", 64'(pending), 1);
    step(8);
    rsp_lanes(4'b0001); step(); idle();
    chk("t1_pend0", 64'(pending), 0);
    ctl_stop = 1; step(); ctl_stop = 0;
    chk("t1_latency", 64'(latency_sum), 9);
    chk("t1_maxpend", 64'(max_pending), 1);
    chk("t1_state_hold", 64'(state), 2);

    // clear, stop-in-idle and start-in-run no-ops, then 4-lane burst
    ctl_clear = 1; step(); ctl_clear = 0;
    chk("t2_clr_reads", 64'(reads), 0);
    chk("t2_clr_state", 64'(state), 0);
    ctl_stop = 1; step(); ctl_stop = 0;
    chk("t2_stop_idle", 64'(state), 0);
    ctl_start = 1; step(2); ctl_start = 0;
    chk("t2_start_run", 64'(state), 1);
    rd_lanes(4'b1111); step(); idle(); step();
    chk("t2_pend4", 64'(pending), 4);
    rsp_lanes(4'b0011); step();
    chk("t2_pend2", 64'(pending), 2);
    step(); idle();
    chk("t2_pend0", 64'(pending), 0);
    chk("t2_reads", 64'(reads), 4);
    chk("t2_maxpend", 64'(max_pending), 4);
    chk("t2_latency", 64'(latency_sum), 6);

    // hold freezes counters but pending still tracks
    ctl_clear = 1; step(); ctl_clear = 0;
    ctl_start = 1; step(); ctl_start = 0;
    req_valid = 4'b0111; req_ready = 4'b1111; req_rw = 4'b0000; step(); idle();
    ctl_stop = 1; step(); ctl_stop = 0;
    chk("t3_hold_state", 64'(state), 2);
    req_valid = 4'b1011; req_ready = 4'b0011; req_rw = 4'b1011;
    rsp_valid = 4'b0011; rsp_ready = 4'b0111;
    step(); idle(); step();
    ctl_start = 1; step(); ctl_start = 0;
    chk("t3_reads", 64'(reads), 3);
    chk("t3_writes", 64'(writes), 0);
    chk("t3_pend", 64'(pending), 1);
    chk("t3_state", 64'(state), 1);
    rsp_lanes(4'b0001); step(); idle();

    // underflow with nothing outstanding
    rsp_lanes(4'b0010); step(); idle();
    chk("t4_pend", 64'(pending), 0);
    chk("t4_err", 64'(err_underflow), 1);
    ctl_clear = 1; step(); ctl_clear = 0;
    chk("t4_err_clr", 64'(err_underflow), 0);
    chk("t4_state", 64'(state), 0);

    // clear+start with a read in the same cycle; narrow pending clamps at 7
    ctl_start = 1; step(); ctl_start = 0;
    rd_lanes(4'b1111); step(); rd_lanes(4'b0111); step(); idle(); step(2);
    chk("t5_reads7", 64'(reads), 7);
    ctl_clear = 1; ctl_start = 1; rd_lanes(4'b0001); step(); idle();
    chk("t5_reads0", 64'(reads), 0);
    chk("t5_state", 64'(state), 1);
    step();
    chk("t5_reads1", 64'(reads), 1);
    chk("t5_pend8", 64'(pending), 8);
    chk("t5_s_pend_sat", 64'(s_pending), 7);
    chk("t5_s_maxpend", 64'(s_max_pending), 7);
    rsp_lanes(4'b1111); step(2); idle();
    chk("t5_pend_drained", 64'(pending), 0);

    // counter width boundary on the narrow instance
    ctl_clear = 1; ctl_start = 1; step(); idle();
    for (int i = 0; i < 20; i++) begin
      rd_lanes(4'b0001); step();
    end
    idle(); step(2);
    chk("t6_reads20", 64'(reads), 20);
`ifdef MEM_LAT_MONITOR_SAT_EN
    chk("t6_s_reads", 64'(s_reads), 15);
`else
    chk("t6_s_reads", 64'(s_reads), 4);
`endif
    rsp_lanes(4'b1111); step(5); idle();
    chk("t6_pend0", 64'(pending), 0);

    // reset mid-window, then a response still in flight
    rd_lanes(4'b0011); step(); idle(); step();
    chk("t7_pend2", 64'(pending), 2);
    reset = 1; step(); reset = 0;
    chk("t7_reads", 64'(reads), 0);
    chk("t7_pend", 64'(pending), 0);
    chk("t7_state", 64'(state), 0);
    rsp_lanes(4'b0001); step(); idle();
    chk("t7_err", 64'(err_underflow), 1);
    chk("t7_pend_after", 64'(pending), 0);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lat_monitor.md
Name: mem_lat_monitor

Overview:
- Parametrised multi-channel memory traffic and latency monitor for a core's dcache/icache/smem request buses.
- Counts read and write request fires and response fires across NUM_CHANNELS lanes, and tracks outstanding reads.
- Integrates outstanding reads per cycle into a latency sum, and records the peak outstanding count.
- Adds run/hold/clear window control and an underflow error flag, so software or the bench can measure a bounded region of execution.

Parameters:
- NUM_CHANNELS, 4, number of request/response lanes monitored (1..32).
- CTR_W, 44, width of the reads/writes/latency_sum counters.
- PEND_W, 16, width of the pending and max_pending registers.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ctl_start  in  1  enter or resume RUN.
- ctl_stop  in  1  enter HOLD (counters frozen).
- ctl_clear  in  1  zero the window counters and the error flag.
- req_valid  in  NUM_CHANNELS  per-lane request valid.
- req_ready  in  NUM_CHANNELS  per-lane request ready.
- req_rw  in  NUM_CHANNELS  per-lane request type: 1 = write, 0 = read.
- rsp_valid  in  NUM_CHANNELS  per-lane response valid.
- rsp_ready  in  NUM_CHANNELS  per-lane response ready.
- reads  out  CTR_W  read requests counted in the window.
- writes  out  CTR_W  write requests counted in the window.
- latency_sum  out  CTR_W  sum of pending over RUN cycles.
- pending  out  PEND_W  current outstanding reads.
- max_pending  out  PEND_W  peak value of pending during the window.
- state  out  2  00 = IDLE, 01 = RUN, 10 = HOLD.
- err_underflow  out  1  sticky: a response arrived with no read outstanding.

Behaviour:
- Reset: all outputs 0, state IDLE, internal pipeline registers 0.
- Fire definitions:
  - rd_fire[i] = req_valid & req_ready & ~req_rw.
  - wr_fire[i] = req_valid & req_ready & req_rw.
  - rsp_fire[i] = rsp_valid & rsp_ready.
- Stage 1 (registered): rd_cnt_r and wr_cnt_r are the popcounts of rd_fire and wr_fire, width clog2(NUM_CHANNELS+1). rsp_cnt is the combinational popcount of rsp_fire.
- Stage 2 (pending): pending_next = pending + rd_cnt_r - rsp_cnt, computed at PEND_W+2 bits signed.
  - Below 0: clamp pending to 0 and set err_underflow.
  - Above max: clamp pending to all-ones.
  - pending updates in every state, including IDLE and HOLD, so outstanding state is never lost.
- Window counters, updated only in RUN:
  - reads += rd_cnt_r.
  - writes += wr_cnt_r.
  - latency_sum += pending (the current registered value, before this cycle's update).
  - max_pending = max(max_pending, pending_next after clamping).
- Latency: a read fire in cycle t appears in reads and pending at t+2. A response fire in cycle t reduces pending at t+1.
- FSM:
  - IDLE -start-> RUN.
  - RUN -stop-> HOLD.
  - HOLD -start-> RUN, resuming with accumulated counts.
  - clear in any state -> IDLE.
- Control priority: clear > stop > start.
- clear together with start: counters zeroed and state goes to RUN in the same edge, so the next cycle counts from 0.
- clear zeroes reads, writes, latency_sum, max_pending and err_underflow. It does not touch pending.
- stop while in IDLE and start while in RUN are no-ops.
- Lanes are independent: any lane combination may fire in the same cycle. A request and a response in the same cycle net out per the pending formula.
- Reset asserted mid-window discards all counts. Any responses still in flight after reset raise err_underflow.

Optional Feature:
- Macro: MEM_LAT_MONITOR_SAT_EN.
- Defined: reads, writes and latency_sum saturate at all-ones and hold until clear.
- Undefined: these counters wrap modulo 2^CTR_W.
- pending saturation applies in both builds.

Decomposition:
- Package mem_perf_pkg holds:
  - the state enum (IDLE=2'b00, RUN=2'b01, HOLD=2'b10);
  - the MEM_PERF_CNT_W(n) constant function returning clog2(n+1).
- Sub-module mem_perf_popcount (parameter N) provides a combinational popcount. It is instantiated three times: rd, wr, rsp.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then start; lane 0 does 1 read at cycle 5 and responds at cycle 15 -> reads=1; pending=1 for cycles 7..15 and 0 from cycle 16; latency_sum=9 after stop; max_pending=1.
- NUM_CHANNELS=4, start, all 4 lanes read in one cycle, then 2 responses on each of the next 2 cycles -> reads=4; pending 4→2→0; max_pending=4; latency_sum=6.
- Start, 3 reads, stop, 2 writes plus 2 responses in HOLD, then start -> reads=3, writes=0, pending=1, state=01.
- Response with pending=0 and no reads in flight -> pending stays 0, err_underflow=1; clear -> err_underflow=0, state=00.
- clear and start asserted in the same cycle as 1 read, with reads=7 beforehand -> next cycle reads=0, state=01; the read counts, giving reads=1 one cycle later.
- CTR_W=4, MEM_LAT_MONITOR_SAT_EN defined, 20 single reads in RUN -> reads=15. Same stimulus with the macro undefined -> reads=4.
